// File: rtl/encoder.sv
// Serial frame encoder: start bit, eight data bits, odd parity, then a stop or end-of-message gap.
// Every output is a flop loaded from the next-state decode, so the outputs follow the state with no added lag.
//
//   state | meaning
//   IDLE  | line high, ready for a byte
//   START | line low for one bit time
//   SHIFT | eight data bits then the parity bit
//   STOP  | short high gap between frames of one message
//   EOM   | long high gap after the final frame
module encoder #(
  parameter int ml_fst    = 0,
  parameter int BIT_CLKS  = 8,
  parameter int STOP_CLKS = 2,
  parameter int EOM_CLKS  = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       last,
  output logic       ready,
  output logic       q,
  output logic       busy,
  output logic       frame_done,
  output logic       msg_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    STOP  = 3'd3,
    EOM   = 3'd4
  } state_t;

  localparam logic [7:0] BIT_RLD  = 8'(BIT_CLKS - 1);
  localparam logic [7:0] STOP_RLD = 8'(STOP_CLKS - 1);
  localparam logic [7:0] EOM_RLD  = 8'(EOM_CLKS - 1);
  localparam logic [3:0] PAR_IDX  = 4'd8;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       par_q, par_d;
  logic       last_q, last_d;
  logic       q_q, q_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       fdone_q, fdone_d;
  logic       mdone_q, mdone_d;
  logic       bit_sel;

  // Data bit that goes on the line for the bit index being entered.
  always_comb begin
    if (ml_fst != 0) bit_sel = data_d[3'd7 - idx_d[2:0]];
    else             bit_sel = data_d[idx_d[2:0]];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    last_d  = last_q;
    fdone_d = 1'b0;
    mdone_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid && ready_q) begin
          data_d  = data;
          par_d   = ~^data;
          last_d  = last;
          cnt_d   = BIT_RLD;
          idx_d   = 4'd0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = BIT_RLD;
          idx_d   = 4'd0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (idx_q == PAR_IDX) begin
          fdone_d = 1'b1;
          if (last_q) begin
            cnt_d   = EOM_RLD;
            state_d = EOM;
          end else begin
            cnt_d   = STOP_RLD;
            state_d = STOP;
          end
        end else begin
          cnt_d = BIT_RLD;
          idx_d = idx_q + 4'd1;
        end
      end
      STOP: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d = cnt_q - 8'd1;
      end
      EOM: begin
        if (cnt_q == 8'd0) begin
          mdone_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        idx_d   = 4'd0;
      end
    endcase

    case (state_d)
      START:   q_d = 1'b0;
      SHIFT:   q_d = (idx_d == PAR_IDX) ? par_d : bit_sel;
      default: q_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 4'd0;
      data_q  <= 8'd0;
      par_q   <= 1'b0;
      last_q  <= 1'b0;
      q_q     <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      mdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      last_q  <= last_d;
      q_q     <= q_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      mdone_q <= mdone_d;
    end
  end

  assign ready      = ready_q;
  assign q          = q_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign msg_done   = mdone_q;

endmodule

// File: tb/tb_encoder.sv
// Bench for encoder: an LSB-first and an MSB-first instance share one stimulus stream and
// each feeds a bench-side line receiver that pops expected bytes from its own scoreboard.
module tb_encoder;

  localparam int BIT   = 8;
  localparam int STOPC = 2;
  localparam int EOMC  = 16;
  localparam int FRAME = 10 * BIT;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic [1:0] ready_w, q_w, busy_w, fd_w, md_w;

  int n_asserts = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar K = 0; K < 2; K++) begin : g_lane
    encoder #(.ml_fst(K), .BIT_CLKS(BIT), .STOP_CLKS(STOPC), .EOM_CLKS(EOMC)) u_dut (
      .clk(clk), .n_rst(n_rst), .data(data), .valid(valid), .last(last),
      .ready(ready_w[K]), .q(q_w[K]), .busy(busy_w[K]),
      .frame_done(fd_w[K]), .msg_done(md_w[K])
    );

    exp_t       e;
    logic [9:0] bits;
    logic [9:0] rx;
    logic [7:0] rxb;
    logic       in_frame = 1'b0;
    logic       prev_q = 1'b1;
    logic       have;
    int         off = 0;
    int         last_start = 0;
    int         msg_due = -1;

    always @(negedge clk) begin
      if (!n_rst) begin
        in_frame = 1'b0;
        prev_q   = 1'b1;
        msg_due  = -1;
      end else begin
        if (!in_frame && prev_q && !q_w[K]) begin
          if (K == 0) have = (sb0.size() > 0);
          else        have = (sb1.size() > 0);
          check($sformatf("frame_expected_l%0d", K), have, 1);
          e = '0;
          if (have) begin
            if (K == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
          end
          if (e.b2b) check($sformatf("start_spacing_l%0d", K), cyc - last_start, FRAME + STOPC + 1);
          last_start = cyc;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = (K == 1) ? e.data[7-i] : e.data[i];
          bits[9] = ($countones(e.data) % 2 == 0);
          rx = '1;
          off = 0;
          in_frame = 1'b1;
        end

        if (in_frame) begin
          if (off < FRAME) begin
            check($sformatf("q_l%0d_bit%0d", K, off / BIT), q_w[K], bits[off/BIT]);
            check($sformatf("ready_in_frame_l%0d", K), ready_w[K], 0);
            check($sformatf("busy_in_frame_l%0d", K), busy_w[K], 1);
            check($sformatf("frame_done_early_l%0d", K), fd_w[K], 0);
            if (off % BIT == BIT / 2) rx[off/BIT] = q_w[K];
            off++;
          end else begin
            check($sformatf("frame_done_l%0d", K), fd_w[K], 1);
            check($sformatf("q_after_parity_l%0d", K), q_w[K], 1);
            for (int i = 0; i < 8; i++) rxb[i] = (K == 1) ? rx[8-i] : rx[i+1];
            check($sformatf("rx_byte_l%0d", K), rxb, e.data);
            check($sformatf("rx_parity_odd_l%0d", K), $countones(rx[9:1]) % 2, 1);
            if (e.last) msg_due = cyc + EOMC;
            in_frame = 1'b0;
          end
        end else begin
          check($sformatf("frame_done_idle_l%0d", K), fd_w[K], 0);
        end
        check($sformatf("msg_done_l%0d", K), md_w[K], (cyc == msg_due));
        prev_q = q_w[K];
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l, input logic b2b);
    int n = 0;
    @(negedge clk);
    data  = d;
    last  = l;
    valid = 1'b1;
    while (!ready_w[0]) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        check("ready_timeout", ready_w[0], 1);
        valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    sb0.push_back('{data: d, last: l, b2b: b2b});
    sb1.push_back('{data: d, last: l, b2b: b2b});
  endtask

  task automatic drop_valid();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q"}, q_w, 2'b11);
    check({tag, "_ready"}, ready_w, 2'b00);
    check({tag, "_busy"}, busy_w, 2'b00);
    check({tag, "_frame_done"}, fd_w, 2'b00);
    check({tag, "_msg_done"}, md_w, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed no end of stimulus, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       l;
    logic       prev_last;
    logic       chained;

    #1 n_rst = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    #1 check("ready_before_edge", ready_w, 2'b00);
    @(negedge clk);
    check("ready_first_edge", ready_w, 2'b11);
    check("busy_idle", busy_w, 2'b00);

    send(8'hA5, 1'b1, 1'b0);
    drop_valid();
    repeat (110) @(negedge clk);

    send(8'h01, 1'b1, 1'b0);
    drop_valid();
    repeat (110) @(negedge clk);

    send(8'h00, 1'b0, 1'b0);
    send(8'h7F, 1'b0, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    drop_valid();
    repeat (110) @(negedge clk);

    send(8'h3C, 1'b1, 1'b0);
    repeat (40) begin
      @(negedge clk);
      valid = 1'($urandom);
      data  = 8'($urandom);
      last  = 1'($urandom);
    end
    valid = 1'b0;
    repeat (80) @(negedge clk);

    send(8'h96, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #2;
    valid = 1'b0;
    n_rst = 1'b0;
    #1 check_reset_outputs("mid_frame_rst");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", ready_w, 2'b11);
    send(8'h5A, 1'b1, 1'b0);
    drop_valid();
    repeat (110) @(negedge clk);

    prev_last = 1'b1;
    chained   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      l = ($urandom_range(3) == 0) || (i == 23);
      send(d, l, chained && !prev_last);
      if ($urandom_range(1) == 1) begin
        chained = 1'b1;
      end else begin
        chained = 1'b0;
        drop_valid();
        repeat ($urandom_range(5)) @(negedge clk);
      end
      prev_last = l;
    end
    drop_valid();
    repeat (130) @(negedge clk);

    check("sb_empty_l0", sb0.size(), 0);
    check("sb_empty_l1", sb1.size(), 0);
    check("final_idle_busy", busy_w, 2'b00);
    check("final_idle_ready", ready_w, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
